// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single regfile write port: one-entry buffer per
// port, fixed priority to A with a starvation guard for B and same-register age ordering.
module regfile_wr_arbiter #(
   parameter int REG_DATA_WIDTH     = 32,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int REGFILE_DEPTH      = 32,
   parameter int STARVE_LIMIT       = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          a_valid_i,
   output logic                          a_ready_o,
   input  logic [REGFILE_ADDR_WIDTH-1:0] a_addr_i,
   input  logic [REG_DATA_WIDTH-1:0]     a_data_i,
   input  logic                          b_valid_i,
   output logic                          b_ready_o,
   input  logic [REGFILE_ADDR_WIDTH-1:0] b_addr_i,
   input  logic [REG_DATA_WIDTH-1:0]     b_data_i,
   output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
   output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
   output logic                          rd_wr_en_o,
   output logic [REGFILE_DEPTH-1:0]      busy_o
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic                          a_full, b_full, a_age, b_age;
   logic [REGFILE_ADDR_WIDTH-1:0] a_addr, b_addr;
   logic [REG_DATA_WIDTH-1:0]     a_data, b_data;
   logic [CW-1:0]                 starve_cnt;

   logic grant_a, grant_b;
   logic a_load, b_load, a_stays, b_stays;
   logic a_age_n, b_age_n;

   // Grant depends only on registered state; reset masks it so a stale entry never writes.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!reset_i) begin
         if (a_full && !b_full)                       grant_a = 1'b1;
         else if (b_full && !a_full)                  grant_b = 1'b1;
         else if (a_full && b_full) begin
            if (a_addr == b_addr) begin
               grant_a = a_age;
               grant_b = ~a_age;
            end else if (starve_cnt == CW'(STARVE_LIMIT)) grant_b = 1'b1;
            else                                      grant_a = 1'b1;
         end
      end
   end

   assign a_ready_o = ~reset_i & (~a_full | grant_a);
   assign b_ready_o = ~reset_i & (~b_full | grant_b);

   // x0 transfers complete the handshake but never occupy the buffer.
   assign a_load  = a_valid_i & a_ready_o & (a_addr_i != '0);
   assign b_load  = b_valid_i & b_ready_o & (b_addr_i != '0);
   assign a_stays = a_full & ~grant_a;
   assign b_stays = b_full & ~grant_b;

   always_comb begin
      a_age_n = a_age;
      b_age_n = b_age;
      if (a_load && b_load) begin
         a_age_n = 1'b0;
         b_age_n = 1'b1;
      end else if (a_load) begin
         a_age_n = ~b_stays;
         b_age_n = b_stays;
      end else if (b_load) begin
         b_age_n = ~a_stays;
         a_age_n = a_stays;
      end else if (!(a_stays && b_stays)) begin
         a_age_n = a_stays;
         b_age_n = b_stays;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         a_full     <= 1'b0;
         b_full     <= 1'b0;
         a_age      <= 1'b0;
         b_age      <= 1'b0;
         a_addr     <= '0;
         b_addr     <= '0;
         a_data     <= '0;
         b_data     <= '0;
         starve_cnt <= '0;
      end else begin
         a_full <= a_load | a_stays;
         b_full <= b_load | b_stays;
         a_age  <= a_age_n;
         b_age  <= b_age_n;
         if (a_load) begin
            a_addr <= a_addr_i;
            a_data <= a_data_i;
         end
         if (b_load) begin
            b_addr <= b_addr_i;
            b_data <= b_data_i;
         end
         if (!b_full || grant_b)
            starve_cnt <= '0;
         else if (grant_a && starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign rd_wr_en_o   = grant_a | grant_b;
   assign rd_addr_o    = grant_a ? a_addr : (grant_b ? b_addr : '0);
   assign rd_wr_data_o = grant_a ? a_data : (grant_b ? b_data : '0);

   always_comb begin
      busy_o = '0;
      if (!reset_i) begin
         if (a_full) busy_o[a_addr] = 1'b1;
         if (b_full) busy_o[b_addr] = 1'b1;
      end
      busy_o[0] = 1'b0;
   end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, streaming, same-cycle ordering,
// starvation guard, x0 discard and mid-operation reset.
module tb_regfile_wr_arbiter;
   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        a_valid_i, b_valid_i;
   logic        a_ready_o, b_ready_o;
   logic [4:0]  a_addr_i, b_addr_i, rd_addr_o;
   logic [31:0] a_data_i, b_data_i, rd_wr_data_o, busy_o;
   logic        rd_wr_en_o;
   logic [31:0] rf [32];
   int          total = 0;
   int          bad = 0;

   regfile_wr_arbiter dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
      .rd_addr_o(rd_addr_o), .rd_wr_data_o(rd_wr_data_o), .rd_wr_en_o(rd_wr_en_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference regfile fed by the write port.
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always @(posedge clk_i) if (rd_wr_en_o) rf[rd_addr_o] <= rd_wr_data_o;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input string tag, input logic en, input logic [4:0] ad, input logic [31:0] dt);
      chk({tag, "_en"}, {31'd0, rd_wr_en_o}, {31'd0, en});
      chk({tag, "_addr"}, {27'd0, rd_addr_o}, {27'd0, ad});
      chk({tag, "_data"}, rd_wr_data_o, dt);
   endtask

   initial begin
      reset_i = 1'b1; a_valid_i = 0; b_valid_i = 0;
      a_addr_i = 0; b_addr_i = 0; a_data_i = 0; b_data_i = 0;
      // reset
      @(negedge clk_i);
      wr("rst", 0, 0, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ardy", {31'd0, a_ready_o}, 0);
      chk("rst_brdy", {31'd0, b_ready_o}, 0);
      tick(); tick();
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_ardy", {31'd0, a_ready_o}, 1);
      chk("post_rst_brdy", {31'd0, b_ready_o}, 1);
      wr("post_rst", 0, 0, 0);
      tick();

      // back-to-back on A
      a_valid_i = 1; a_addr_i = 5; a_data_i = 32'h11;
      @(negedge clk_i); chk("b2b_rdy0", {31'd0, a_ready_o}, 1); wr("b2b_c0", 0, 0, 0);
      tick(); a_addr_i = 6; a_data_i = 32'h22;
      @(negedge clk_i); wr("b2b_c1", 1, 5, 32'h11); chk("b2b_rdy1", {31'd0, a_ready_o}, 1);
      chk("b2b_busy1", busy_o, 32'h20);
      tick(); a_addr_i = 7; a_data_i = 32'h33;
      @(negedge clk_i); wr("b2b_c2", 1, 6, 32'h22); chk("b2b_rdy2", {31'd0, a_ready_o}, 1);
      tick(); a_valid_i = 0;
      @(negedge clk_i); wr("b2b_c3", 1, 7, 32'h33); chk("b2b_rdy3", {31'd0, a_ready_o}, 1);
      tick();
      @(negedge clk_i); wr("b2b_c4", 0, 0, 0);

      // same cycle, different registers
      a_valid_i = 1; a_addr_i = 3; a_data_i = 32'hA;
      b_valid_i = 1; b_addr_i = 4; b_data_i = 32'hB;
      tick(); a_valid_i = 0; b_valid_i = 0;
      @(negedge clk_i); wr("diff_c1", 1, 3, 32'hA);
      chk("diff_busy1", busy_o, 32'h18); chk("diff_brdy1", {31'd0, b_ready_o}, 0);
      tick();
      @(negedge clk_i); wr("diff_c2", 1, 4, 32'hB);
      chk("diff_busy2", busy_o, 32'h10); chk("diff_brdy2", {31'd0, b_ready_o}, 1);
      tick();
      @(negedge clk_i); wr("diff_c3", 0, 0, 0); chk("diff_busy3", busy_o, 0);

      // same cycle, same register: B is older
      a_valid_i = 1; a_addr_i = 9; a_data_i = 32'h1;
      b_valid_i = 1; b_addr_i = 9; b_data_i = 32'h2;
      tick(); a_valid_i = 0; b_valid_i = 0;
      @(negedge clk_i); wr("same_c1", 1, 9, 32'h2); chk("same_busy1", busy_o, 32'h200);
      tick();
      @(negedge clk_i); wr("same_c2", 1, 9, 32'h1);
      tick();
      @(negedge clk_i); wr("same_c3", 0, 0, 0); chk("same_rf9", rf[9], 32'h1);

      // starvation guard: B holds x8 while A streams x10..x15
      a_valid_i = 1; a_addr_i = 10; a_data_i = 32'h100 + 10;
      b_valid_i = 1; b_addr_i = 8;  b_data_i = 32'h80;
      tick(); b_valid_i = 0;
      for (int k = 0; k < 4; k++) begin
         a_addr_i = 5'(11 + k); a_data_i = 32'h100 + 32'(11 + k);
         @(negedge clk_i);
         wr($sformatf("starve_a%0d", k), 1, 5'(10 + k), 32'h100 + 32'(10 + k));
         tick();
      end
      a_addr_i = 15; a_data_i = 32'h100 + 15;
      @(negedge clk_i); wr("starve_b", 1, 8, 32'h80);
      chk("starve_ardy", {31'd0, a_ready_o}, 0);
      chk("starve_cnt_full", 32'(dut.starve_cnt), 4);
      tick(); a_valid_i = 0;
      @(negedge clk_i); wr("starve_resume", 1, 14, 32'h100 + 14);
      chk("starve_cnt_clr", 32'(dut.starve_cnt), 0);
      tick();
      @(negedge clk_i); wr("starve_idle", 0, 0, 0); chk("starve_rf8", rf[8], 32'h80);

      // x0 write is accepted and dropped
      a_valid_i = 1; a_addr_i = 0; a_data_i = 32'hDEAD;
      @(negedge clk_i); chk("x0_rdy0", {31'd0, a_ready_o}, 1);
      tick(); a_valid_i = 0;
      @(negedge clk_i); wr("x0_c1", 0, 0, 0);
      chk("x0_busy", busy_o, 0); chk("x0_rdy1", {31'd0, a_ready_o}, 1);
      tick();
      @(negedge clk_i); wr("x0_c2", 0, 0, 0); chk("x0_rf0", rf[0], 0);

      // mid-operation reset with both buffers full
      a_valid_i = 1; a_addr_i = 1; a_data_i = 32'h55;
      b_valid_i = 1; b_addr_i = 2; b_data_i = 32'h66;
      tick(); a_valid_i = 0; b_valid_i = 0; reset_i = 1;
      @(negedge clk_i); wr("mrst_c1", 0, 0, 0); chk("mrst_busy1", busy_o, 0);
      tick(); reset_i = 0;
      @(negedge clk_i); wr("mrst_c2", 0, 0, 0); chk("mrst_busy2", busy_o, 0);
      chk("mrst_ardy", {31'd0, a_ready_o}, 1); chk("mrst_brdy", {31'd0, b_ready_o}, 1);
      tick();
      @(negedge clk_i); wr("mrst_c3", 0, 0, 0);
      chk("mrst_rf1", rf[1], 0); chk("mrst_rf2", rf[2], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
